instruction_decode_stage: RTL and testbench
===========================================

Name: instruction_decode_stage

Overview:
MIPS ID stage that sits directly downstream of instruction fetch and consumes its instruction and PC+4 every cycle. It holds the IF/ID pipeline register, the 32x32 register file, main control decode and load-use/branch hazard detection. Branches and jumps resolve here; the block returns branch/jump targets and a stall signal to fetch, and drives a registered ID/EX bundle to execute.

Parameters:
REG_COUNT, 32, number of architectural registers; r0 is hardwired to zero.
NOP_WORD, 32'h0000_0000, word loaded into IF/ID on flush or reset (sll r0,r0,0).

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
instruction_in  in  32  fetched instruction from IF
pc4_in  in  32  PC+4 of the fetched instruction
wb_reg_write  in  1  writeback enable
wb_write_reg  in  5  writeback destination
wb_write_data  in  32  writeback data
ex_mem_read  in  1  instruction currently in EX is a load
ex_reg_write  in  1  instruction currently in EX writes a register
ex_dest_reg  in  5  destination register of the EX instruction
mem_mem_read  in  1  instruction currently in MEM is a load
mem_dest_reg  in  5  destination register of the MEM instruction
hazard_out  out  1  stall request to IF (PC hold); combinational
branch_taken_out  out  1  redirect PC to pc_branch_out; combinational
pc_branch_out  out  32  pc4 + (sign-extended imm << 2)
jump_out  out  1  redirect PC to pc_jump_out; combinational
pc_jump_out  out  32  {pc4[31:28], instr[25:0], 2'b00}
id_ex_read_data1  out  32  registered rs value
id_ex_read_data2  out  32  registered rt value
id_ex_imm  out  32  registered sign/zero-extended immediate
id_ex_rs, id_ex_rt, id_ex_rd  out  5 each  registered register fields
id_ex_pc4  out  32  registered PC+4
id_ex_ctrl  out  10  registered {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op[3:0]}

Behaviour:
- Reset (reset=0, async): IF/ID = NOP_WORD, IF/ID pc4 = 0, all registers = 0, all id_ex_* outputs = 0. Combinational outputs then decode a NOP: hazard_out=0, branch_taken_out=0, jump_out=0.
- IF/ID register, per posedge, in priority order:
  - hazard_out=1 -> hold.
  - Else branch_taken_out or jump_out -> load NOP_WORD, one-slot squash.
  - Else load instruction_in / pc4_in.
- Register file:
  - Write at posedge when wb_reg_write=1 and wb_write_reg!=0.
  - Reads are combinational with write-through: same-cycle write to the read address returns wb_write_data.
  - Reads of r0 always return 0.
- Decode (opcode hex):
  - 00 R-type: reg_dst=1, reg_write=1, alu_op from funct.
  - 23 lw, 2B sw, 04 beq, 05 bne, 08 addi, 0A slti, 0C andi, 0D ori, 02 j.
  - andi/ori zero-extend the immediate; all others sign-extend.
  - Unknown opcode -> all control bits 0.
- Hazard detection (hazard_out=1), combinational:
  - Load-use: ex_mem_read and ex_dest_reg!=0 and ex_dest_reg matches rs, or matches rt for R-type/sw/beq/bne.
  - Branch operand: beq/bne and ex_reg_write and ex_dest_reg!=0 matches rs/rt.
  - Branch after load: beq/bne and mem_mem_read and mem_dest_reg!=0 matches rs/rt.
- Branch/jump outputs:
  - branch_taken_out = (beq & rs_val==rt_val | bne & rs_val!=rt_val) & ~hazard_out.
  - jump_out = (opcode==02) & ~hazard_out.
- ID/EX register, per posedge:
  - hazard_out=1 -> bubble: id_ex_ctrl=0, other fields don't-care (driven 0).
  - Else capture the decoded bundle.
  - Latency: instruction in IF/ID at edge N appears on id_ex_* after edge N+1.
- Simultaneous events:
  - Stall beats flush.
  - A writeback to a register the stalled instruction reads is visible through write-through.
  - Reset mid-stall clears everything with no residual hazard.
- Arithmetic: pc_branch_out uses 32-bit wrap-around addition; no overflow flag.

Decomposition:
- Package mips_pkg: opcode and funct localparams, alu_op enum (4-bit), packed control struct matching id_ex_ctrl ordering, NOP_WORD constant.
- Sub-module register_file: 32x32 array, two read ports, one write port, write-through, r0 zero, async active-low clear.

Test Plan:
- Reset: assert reset=0 mid-stream -> all id_ex_* = 0 and hazard_out=0 immediately; register r5 reads 0 afterwards.
- Write-through: wb writes r3=32'hDEAD_BEEF in the same cycle add r1,r3,r3 is in IF/ID -> id_ex_read_data1 = id_ex_read_data2 = DEADBEEF next edge. A write to r0 is ignored.
- Load-use: lw r2 in EX (ex_mem_read=1, ex_dest_reg=2), add r4,r2,r1 in IF/ID -> hazard_out=1 for 1 cycle, id_ex_ctrl=0 bubble, IF/ID holds; add issues on the following edge.
- Branch taken: beq r1,r1,+4 at pc4=0x10 -> branch_taken_out=1, pc_branch_out=0x20, IF/ID holds NOP_WORD after the edge. With r1!=r2, beq r1,r2 -> not taken, no flush.
- Jump: j 0x0000040 with pc4=0x9000_0004 -> jump_out=1, pc_jump_out=0x9000_0100, next IF/ID = NOP.
- Branch after load: beq r2,r0 with mem_mem_read=1, mem_dest_reg=2 -> hazard_out=1, branch_taken_out=0 that cycle; resolves correctly the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, functs, ALU ops, control and ID/EX payloads.
package mips_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned CTRL_W    = 10;

  // sll r0,r0,0
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOR = 4'h5,
    ALU_SLT = 4'h6,
    ALU_SLL = 4'h7,
    ALU_SRL = 4'h8,
    ALU_SRA = 4'h9
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   read_data1;
    logic [XLEN-1:0]   read_data2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc4;
    ctrl_t             ctrl;
  } id_ex_t;

  // Unknown functs fall back to add.
  function automatic alu_op_e alu_from_funct(input logic [5:0] funct);
    alu_op_e op;
    case (funct)
      FN_SLL:          op = ALU_SLL;
      FN_SRL:          op = ALU_SRL;
      FN_SRA:          op = ALU_SRA;
      FN_ADD, FN_ADDU: op = ALU_ADD;
      FN_SUB, FN_SUBU: op = ALU_SUB;
      FN_AND:          op = ALU_AND;
      FN_OR:           op = ALU_OR;
      FN_XOR:          op = ALU_XOR;
      FN_NOR:          op = ALU_NOR;
      FN_SLT:          op = ALU_SLT;
      default:         op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Signal bundle between the ID stage and its neighbours (IF, EX, MEM, WB).
interface instruction_decode_stage_if;
  import mips_pkg::*;

  logic [XLEN-1:0]   instruction_in;
  logic [XLEN-1:0]   pc4_in;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_write_reg;
  logic [XLEN-1:0]   wb_write_data;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [REG_AW-1:0] ex_dest_reg;
  logic              mem_mem_read;
  logic [REG_AW-1:0] mem_dest_reg;

  logic              hazard_out;
  logic              branch_taken_out;
  logic [XLEN-1:0]   pc_branch_out;
  logic              jump_out;
  logic [XLEN-1:0]   pc_jump_out;
  logic [XLEN-1:0]   id_ex_read_data1;
  logic [XLEN-1:0]   id_ex_read_data2;
  logic [XLEN-1:0]   id_ex_imm;
  logic [REG_AW-1:0] id_ex_rs;
  logic [REG_AW-1:0] id_ex_rt;
  logic [REG_AW-1:0] id_ex_rd;
  logic [XLEN-1:0]   id_ex_pc4;
  logic [CTRL_W-1:0] id_ex_ctrl;

  modport master (
    input  instruction_in, pc4_in,
    input  wb_reg_write, wb_write_reg, wb_write_data,
    input  ex_mem_read, ex_reg_write, ex_dest_reg,
    input  mem_mem_read, mem_dest_reg,
    output hazard_out, branch_taken_out, pc_branch_out, jump_out, pc_jump_out,
    output id_ex_read_data1, id_ex_read_data2, id_ex_imm,
    output id_ex_rs, id_ex_rt, id_ex_rd, id_ex_pc4, id_ex_ctrl
  );

  modport slave (
    output instruction_in, pc4_in,
    output wb_reg_write, wb_write_reg, wb_write_data,
    output ex_mem_read, ex_reg_write, ex_dest_reg,
    output mem_mem_read, mem_dest_reg,
    input  hazard_out, branch_taken_out, pc_branch_out, jump_out, pc_jump_out,
    input  id_ex_read_data1, id_ex_read_data2, id_ex_imm,
    input  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_pc4, id_ex_ctrl
  );

endinterface

// File: rtl/register_file.sv
// 2R1W architectural register file; r0 reads zero, reads see a same-cycle write.
module register_file
  import mips_pkg::*;
#(
  parameter int unsigned REG_COUNT_P = REG_COUNT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [$clog2(REG_COUNT_P)-1:0] ra1,
  input  logic [$clog2(REG_COUNT_P)-1:0] ra2,
  output logic [XLEN-1:0]                rd1,
  output logic [XLEN-1:0]                rd2,
  input  logic                           we,
  input  logic [$clog2(REG_COUNT_P)-1:0] wa,
  input  logic [XLEN-1:0]                wd
);

  logic [XLEN-1:0] regs [REG_COUNT_P];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT_P; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // Write-through bypass so ID sees the value WB is committing this cycle.
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: IF/ID register, register file, control decode, hazard
// detection, branch/jump resolution and the ID/EX pipeline register.
module instruction_decode_stage
  import mips_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  instruction_decode_stage_if.master bus
);

  logic [XLEN-1:0]   if_id_instr;
  logic [XLEN-1:0]   if_id_pc4;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [15:0]       imm16;
  logic [XLEN-1:0]   rs_val;
  logic [XLEN-1:0]   rt_val;

  ctrl_t             ctrl;
  logic              imm_zext;
  logic              uses_rt;
  logic              is_beq;
  logic              is_bne;
  logic              is_jump;
  logic [XLEN-1:0]   imm_ext;
  logic              load_use;
  logic              branch_ex_dep;
  logic              branch_mem_dep;
  logic              hazard;
  logic              branch_taken;
  logic              jump;

  id_ex_t            id_ex_d;
  id_ex_t            id_ex_q;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];
  assign funct  = if_id_instr[5:0];
  assign imm16  = if_id_instr[15:0];

  // Stall holds the slot; a redirect squashes the fall-through fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
    end else if (!hazard) begin
      if (branch_taken || jump) begin
        if_id_instr <= NOP_WORD;
        if_id_pc4   <= '0;
      end else begin
        if_id_instr <= bus.instruction_in;
        if_id_pc4   <= bus.pc4_in;
      end
    end
  end

  register_file #(.REG_COUNT_P(REG_COUNT)) u_register_file (
    .clk   (clk),
    .rst_n (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (bus.wb_reg_write),
    .wa    (bus.wb_write_reg),
    .wd    (bus.wb_write_data)
  );

  // Main control decode.
  always_comb begin
    ctrl     = '0;
    imm_zext = 1'b0;
    uses_rt  = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_jump  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = alu_from_funct(funct);
        uses_rt        = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        uses_rt     = 1'b1;
        is_beq      = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op = ALU_SUB;
        uses_rt     = 1'b1;
        is_bne      = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_SLTI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_SLT;
      end
      OP_ANDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_AND;
        imm_zext       = 1'b1;
      end
      OP_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OR;
        imm_zext       = 1'b1;
      end
      OP_J:    is_jump = 1'b1;
      default: ;
    endcase
  end

  assign imm_ext = imm_zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};

  // Branches compare in ID, so they also wait on producers still in EX or MEM.
  assign load_use = bus.ex_mem_read && (bus.ex_dest_reg != '0) &&
                    ((bus.ex_dest_reg == rs) || (uses_rt && bus.ex_dest_reg == rt));
  assign branch_ex_dep = (is_beq || is_bne) && bus.ex_reg_write && (bus.ex_dest_reg != '0) &&
                         ((bus.ex_dest_reg == rs) || (bus.ex_dest_reg == rt));
  assign branch_mem_dep = (is_beq || is_bne) && bus.mem_mem_read && (bus.mem_dest_reg != '0) &&
                          ((bus.mem_dest_reg == rs) || (bus.mem_dest_reg == rt));
  assign hazard = load_use || branch_ex_dep || branch_mem_dep;

  assign branch_taken = ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val)) && !hazard;
  assign jump         = is_jump && !hazard;

  assign bus.hazard_out       = hazard;
  assign bus.branch_taken_out = branch_taken;
  assign bus.jump_out         = jump;
  assign bus.pc_branch_out    = if_id_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign bus.pc_jump_out      = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

  always_comb begin
    id_ex_d            = '0;
    id_ex_d.read_data1 = rs_val;
    id_ex_d.read_data2 = rt_val;
    id_ex_d.imm        = imm_ext;
    id_ex_d.rs         = rs;
    id_ex_d.rt         = rt;
    id_ex_d.rd         = rd;
    id_ex_d.pc4        = if_id_pc4;
    id_ex_d.ctrl       = ctrl;
  end

  // A stall sends an all-zero bubble into EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_q <= '0;
    end else if (hazard) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign bus.id_ex_read_data1 = id_ex_q.read_data1;
  assign bus.id_ex_read_data2 = id_ex_q.read_data2;
  assign bus.id_ex_imm        = id_ex_q.imm;
  assign bus.id_ex_rs         = id_ex_q.rs;
  assign bus.id_ex_rt         = id_ex_q.rt;
  assign bus.id_ex_rd         = id_ex_q.rd;
  assign bus.id_ex_pc4        = id_ex_q.pc4;
  assign bus.id_ex_ctrl       = id_ex_q.ctrl;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: decode table plus hazard/redirect/reset sequences.
module tb_instruction_decode_stage;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  instruction_decode_stage_if bus ();

  instruction_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        br_op;
    logic        br;
    logic        jmp;
    logic [31:0] pcb;
    logic [31:0] pcj;
    logic [9:0]  ctrl;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] pc4,
                               input logic br_op, input logic br, input logic jmp,
                               input logic [31:0] pcb, input logic [31:0] pcj,
                               input logic [9:0] ctrl, input logic [31:0] imm,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    vec_t v;
    v.instr = instr; v.pc4 = pc4; v.br_op = br_op; v.br = br; v.jmp = jmp;
    v.pcb = pcb; v.pcj = pcj; v.ctrl = ctrl; v.imm = imm; v.d1 = d1; v.d2 = d2;
    v.rs = rs; v.rt = rt; v.rd = rd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_side();
    bus.wb_reg_write  = 1'b0;
    bus.wb_write_reg  = 5'd0;
    bus.wb_write_data = 32'h0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_reg_write  = 1'b0;
    bus.ex_dest_reg   = 5'd0;
    bus.mem_mem_read  = 1'b0;
    bus.mem_dest_reg  = 5'd0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = r;
    bus.wb_write_data = d;
  endtask

  logic [31:0] marker;
  logic        prev_flush;

  initial begin
    marker = enc_i(OP_ADDI, 5'd0, 5'd9, 16'h0055);
    // r1=5, r2=7 for the whole table; other registers stay 0.
    vecs[0]  = mkv(enc_r(5'd1, 5'd2, 5'd4, 6'h20), 32'h100, 0, 0, 0, 0, 0, 10'h210, 32'h2020, 32'd5, 32'd7, 5'd1, 5'd2, 5'd4);
    vecs[1]  = mkv(enc_r(5'd2, 5'd1, 5'd5, 6'h22), 32'h104, 0, 0, 0, 0, 0, 10'h211, 32'h2822, 32'd7, 32'd5, 5'd2, 5'd1, 5'd5);
    vecs[2]  = mkv(enc_r(5'd1, 5'd2, 5'd6, 6'h2A), 32'h108, 0, 0, 0, 0, 0, 10'h216, 32'h302A, 32'd5, 32'd7, 5'd1, 5'd2, 5'd6);
    vecs[3]  = mkv(enc_i(OP_LW, 5'd1, 5'd6, 16'hFFFC), 32'h10C, 0, 0, 0, 0, 0, 10'h1B0, 32'hFFFF_FFFC, 32'd5, 32'd0, 5'd1, 5'd6, 5'd31);
    vecs[4]  = mkv(enc_i(OP_SW, 5'd1, 5'd2, 16'h0008), 32'h110, 0, 0, 0, 0, 0, 10'h140, 32'h8, 32'd5, 32'd7, 5'd1, 5'd2, 5'd0);
    vecs[5]  = mkv(enc_i(OP_ADDI, 5'd1, 5'd7, 16'hFFFF), 32'h114, 0, 0, 0, 0, 0, 10'h110, 32'hFFFF_FFFF, 32'd5, 32'd0, 5'd1, 5'd7, 5'd31);
    vecs[6]  = mkv(enc_i(OP_SLTI, 5'd2, 5'd7, 16'h8000), 32'h118, 0, 0, 0, 0, 0, 10'h116, 32'hFFFF_8000, 32'd7, 32'd0, 5'd2, 5'd7, 5'd16);
    vecs[7]  = mkv(enc_i(OP_ANDI, 5'd2, 5'd7, 16'h8000), 32'h11C, 0, 0, 0, 0, 0, 10'h112, 32'h0000_8000, 32'd7, 32'd0, 5'd2, 5'd7, 5'd16);
    vecs[8]  = mkv(enc_i(OP_ORI, 5'd1, 5'd7, 16'hFFFF), 32'h120, 0, 0, 0, 0, 0, 10'h113, 32'h0000_FFFF, 32'd5, 32'd0, 5'd1, 5'd7, 5'd31);
    vecs[9]  = mkv(enc_i(OP_BEQ, 5'd1, 5'd2, 16'h0004), 32'h200, 1, 0, 0, 32'h210, 0, 10'h001, 32'h4, 32'd5, 32'd7, 5'd1, 5'd2, 5'd0);
    vecs[10] = mkv(enc_i(OP_BNE, 5'd1, 5'd2, 16'hFFFE), 32'h200, 1, 1, 0, 32'h1F8, 0, 10'h001, 32'hFFFF_FFFE, 32'd5, 32'd7, 5'd1, 5'd2, 5'd31);
    vecs[11] = mkv(enc_i(OP_BEQ, 5'd1, 5'd1, 16'h0004), 32'h10, 1, 1, 0, 32'h20, 0, 10'h001, 32'h4, 32'd5, 32'd5, 5'd1, 5'd1, 5'd0);
    vecs[12] = mkv({6'h02, 26'h000_0040}, 32'h9000_0004, 0, 0, 1, 0, 32'h9000_0100, 10'h000, 32'h40, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    vecs[13] = mkv(enc_i(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h124, 0, 0, 0, 0, 0, 10'h000, 32'h1234, 32'd5, 32'd7, 5'd1, 5'd2, 5'd2);
    vecs[14] = mkv(enc_i(OP_BEQ, 5'd0, 5'd0, 16'h0004), 32'hFFFF_FFF0, 1, 1, 0, 32'h0, 0, 10'h001, 32'h4, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

    reset = 1'b0;
    bus.instruction_in = NOP_WORD;
    bus.pc4_in = 32'h0;
    clear_side();
    #3;
    check("rst_ctrl", 32'(bus.id_ex_ctrl), 32'h0);
    check("rst_pc4", bus.id_ex_pc4, 32'h0);
    check("rst_hazard", 32'(bus.hazard_out), 32'h0);
    check("rst_branch", 32'(bus.branch_taken_out), 32'h0);
    check("rst_jump", 32'(bus.jump_out), 32'h0);
    #10;
    reset = 1'b1;

    wb_write(5'd1, 32'd5);       step();
    wb_write(5'd2, 32'd7);       step();
    wb_write(5'd5, 32'h55AA);    step();
    clear_side();

    // Write-through to a register the IF/ID instruction reads.
    bus.instruction_in = enc_r(5'd3, 5'd3, 5'd1, 6'h20); step();
    bus.instruction_in = NOP_WORD;
    wb_write(5'd3, 32'hDEAD_BEEF); step();
    clear_side();
    check("wt_d1", bus.id_ex_read_data1, 32'hDEAD_BEEF);
    check("wt_d2", bus.id_ex_read_data2, 32'hDEAD_BEEF);

    bus.instruction_in = enc_r(5'd0, 5'd3, 5'd1, 6'h20); step();
    bus.instruction_in = NOP_WORD;
    wb_write(5'd0, 32'hFFFF_FFFF); step();
    clear_side();
    check("r0_wt", bus.id_ex_read_data1, 32'h0);
    check("r3_held", bus.id_ex_read_data2, 32'hDEAD_BEEF);
    bus.instruction_in = enc_r(5'd0, 5'd0, 5'd1, 6'h20); step();
    bus.instruction_in = NOP_WORD; step();
    check("r0_after_write", bus.id_ex_read_data1, 32'h0);

    // Decode table; the marker after each entry shows whether it was squashed.
    prev_flush = 1'b0;
    for (int i = 0; i < NV; i++) begin
      bus.instruction_in = vecs[i].instr;
      bus.pc4_in = vecs[i].pc4;
      step();
      if (i > 0) check($sformatf("v%0d_squash", i - 1), 32'(bus.id_ex_ctrl), prev_flush ? 32'h217 : 32'h110);
      bus.instruction_in = marker;
      bus.pc4_in = 32'h0;
      #1;
      check($sformatf("v%0d_hazard", i), 32'(bus.hazard_out), 32'h0);
      check($sformatf("v%0d_branch", i), 32'(bus.branch_taken_out), 32'(vecs[i].br));
      check($sformatf("v%0d_jump", i), 32'(bus.jump_out), 32'(vecs[i].jmp));
      if (vecs[i].br_op) check($sformatf("v%0d_pcb", i), bus.pc_branch_out, vecs[i].pcb);
      if (vecs[i].jmp) check($sformatf("v%0d_pcj", i), bus.pc_jump_out, vecs[i].pcj);
      step();
      check($sformatf("v%0d_ctrl", i), 32'(bus.id_ex_ctrl), 32'(vecs[i].ctrl));
      check($sformatf("v%0d_imm", i), bus.id_ex_imm, vecs[i].imm);
      check($sformatf("v%0d_d1", i), bus.id_ex_read_data1, vecs[i].d1);
      check($sformatf("v%0d_d2", i), bus.id_ex_read_data2, vecs[i].d2);
      check($sformatf("v%0d_rs", i), 32'(bus.id_ex_rs), 32'(vecs[i].rs));
      check($sformatf("v%0d_rt", i), 32'(bus.id_ex_rt), 32'(vecs[i].rt));
      check($sformatf("v%0d_rd", i), 32'(bus.id_ex_rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_pc4", i), bus.id_ex_pc4, vecs[i].pc4);
      prev_flush = vecs[i].br | vecs[i].jmp;
    end
    bus.instruction_in = NOP_WORD;
    step();
    check("vlast_squash", 32'(bus.id_ex_ctrl), prev_flush ? 32'h217 : 32'h110);

    // Load-use: lw r2 in EX, add r4,r2,r1 in ID.
    bus.instruction_in = enc_r(5'd2, 5'd1, 5'd4, 6'h20); step();
    bus.instruction_in = marker;
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dest_reg = 5'd2;
    #1;
    check("lu_hazard", 32'(bus.hazard_out), 32'h1);
    step();
    check("lu_bubble", 32'(bus.id_ex_ctrl), 32'h0);
    clear_side();
    bus.mem_mem_read = 1'b1; bus.mem_dest_reg = 5'd2;
    #1;
    check("lu_clear", 32'(bus.hazard_out), 32'h0);
    step();
    clear_side();
    check("lu_issue", 32'(bus.id_ex_ctrl), 32'h210);
    check("lu_d1", bus.id_ex_read_data1, 32'd7);
    check("lu_d2", bus.id_ex_read_data2, 32'd5);
    check("lu_rd", 32'(bus.id_ex_rd), 32'd4);
    step();
    check("lu_next", bus.id_ex_imm, 32'h55);

    // rt only matters for instructions that read it.
    bus.instruction_in = enc_i(OP_ADDI, 5'd1, 5'd7, 16'h0001); step();
    bus.instruction_in = enc_i(OP_SW, 5'd1, 5'd7, 16'h0000);
    bus.ex_mem_read = 1'b1; bus.ex_dest_reg = 5'd7;
    #1;
    check("lu_rt_itype", 32'(bus.hazard_out), 32'h0);
    clear_side();
    step();
    bus.ex_mem_read = 1'b1; bus.ex_dest_reg = 5'd7;
    #1;
    check("lu_sw_rt", 32'(bus.hazard_out), 32'h1);
    bus.ex_dest_reg = 5'd0;
    #1;
    check("lu_dest0", 32'(bus.hazard_out), 32'h0);
    clear_side();
    bus.instruction_in = NOP_WORD;
    step();

    // Branch operand still being produced in EX.
    bus.instruction_in = enc_i(OP_BEQ, 5'd1, 5'd1, 16'h0004);
    bus.pc4_in = 32'h40;
    step();
    bus.instruction_in = NOP_WORD;
    bus.ex_reg_write = 1'b1; bus.ex_dest_reg = 5'd1;
    #1;
    check("brx_hazard", 32'(bus.hazard_out), 32'h1);
    check("brx_nobranch", 32'(bus.branch_taken_out), 32'h0);
    clear_side();
    #1;
    check("brx_resolved", 32'(bus.branch_taken_out), 32'h1);
    check("brx_pcb", bus.pc_branch_out, 32'h50);
    step();

    // Branch after load: stall beats flush, then resolves with the WB value.
    bus.instruction_in = enc_i(OP_BEQ, 5'd2, 5'd0, 16'h0008);
    bus.pc4_in = 32'h100;
    step();
    bus.instruction_in = marker;
    bus.mem_mem_read = 1'b1; bus.mem_dest_reg = 5'd2;
    #1;
    check("bal_hazard", 32'(bus.hazard_out), 32'h1);
    check("bal_nobranch", 32'(bus.branch_taken_out), 32'h0);
    step();
    check("bal_bubble", 32'(bus.id_ex_ctrl), 32'h0);
    clear_side();
    wb_write(5'd2, 32'h0);
    #1;
    check("bal_clear", 32'(bus.hazard_out), 32'h0);
    check("bal_taken", 32'(bus.branch_taken_out), 32'h1);
    check("bal_pcb", bus.pc_branch_out, 32'h120);
    step();
    clear_side();
    check("bal_issue", 32'(bus.id_ex_ctrl), 32'h001);
    check("bal_d1", bus.id_ex_read_data1, 32'h0);
    step();
    check("bal_squash", 32'(bus.id_ex_ctrl), 32'h217);

    // Reset while stalled.
    bus.instruction_in = enc_r(5'd5, 5'd1, 5'd4, 6'h20); step();
    bus.ex_mem_read = 1'b1; bus.ex_dest_reg = 5'd5;
    #1;
    check("rs_pre_hazard", 32'(bus.hazard_out), 32'h1);
    reset = 1'b0;
    #1;
    check("rs_hazard", 32'(bus.hazard_out), 32'h0);
    check("rs_ctrl", 32'(bus.id_ex_ctrl), 32'h0);
    check("rs_d1", bus.id_ex_read_data1, 32'h0);
    check("rs_pc4", bus.id_ex_pc4, 32'h0);
    clear_side();
    #1;
    reset = 1'b1;
    bus.instruction_in = enc_r(5'd5, 5'd5, 5'd1, 6'h20); step();
    bus.instruction_in = NOP_WORD; step();
    check("r5_cleared_d1", bus.id_ex_read_data1, 32'h0);
    check("r5_cleared_d2", bus.id_ex_read_data2, 32'h0);
    check("r5_issue", 32'(bus.id_ex_ctrl), 32'h210);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
